// File: rtl/id_operand_scoreboard_pkg.sv
// Shared constants for the decode-stage operand scoreboard (package id_sb_pkg).
// Forwarding index constants follow pipeline age: EX is the youngest source.
package id_sb_pkg;
  localparam int REG_AW   = 5;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  // Largest value a pending counter may hold before an issue would wrap it.
  function automatic int cntMax(input int width);
    return (1 << width) - 1;
  endfunction
endpackage

// File: rtl/id_operand_scoreboard_if.sv
// Decode-side operand/forwarding bus of the scoreboard.
// The master modport is the pipeline driving it; the slave modport is the scoreboard.
interface id_operand_scoreboard_if #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3
);
  logic [NUM_RD*5-1:0]     rd_addr;
  logic [NUM_RD-1:0]       rd_need;
  logic [NUM_RD*XLEN-1:0]  rf_rdata;
  logic [NUM_RD*XLEN-1:0]  src_value;
  logic                    stall;
  logic                    issue_valid;
  logic                    issue_we;
  logic [4:0]              issue_waddr;
  logic [4:0]              dst_addr;
  logic                    dst_we;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD-1:0]      fwd_we;
  logic [NUM_FWD*5-1:0]    fwd_waddr;
  logic [NUM_FWD-1:0]      fwd_data_ok;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    retire_valid;
  logic [4:0]              retire_waddr;
  logic [XLEN-1:0]         retire_wdata;
  logic                    flush_all;
  logic [NREG-1:0]         busy_mask;
  logic                    sb_err;

  modport master (
    output rd_addr, rd_need, rf_rdata, issue_valid, issue_we, issue_waddr,
           dst_addr, dst_we, fwd_valid, fwd_we, fwd_waddr, fwd_data_ok, fwd_data,
           retire_valid, retire_waddr, retire_wdata, flush_all,
    input  src_value, stall, busy_mask, sb_err
  );

  modport slave (
    input  rd_addr, rd_need, rf_rdata, issue_valid, issue_we, issue_waddr,
           dst_addr, dst_we, fwd_valid, fwd_we, fwd_waddr, fwd_data_ok, fwd_data,
           retire_valid, retire_waddr, retire_wdata, flush_all,
    output src_value, stall, busy_mask, sb_err
  );
endinterface

// File: rtl/id_operand_scoreboard_fwd_mux.sv
// Single read-port operand resolver: r0, prioritised forwarding, WB commit, register file.
// Forwarding and commit bypass exist only when SB_BYPASS_EN is defined.
module id_fwd_mux
  import id_sb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_AW-1:0]         i_addr,
  input  logic                      i_need,
  input  logic [XLEN-1:0]           i_rfData,
  input  logic                      i_pending,
  input  logic [NUM_FWD-1:0]        i_fwdValid,
  input  logic [NUM_FWD-1:0]        i_fwdWe,
  input  logic [NUM_FWD*REG_AW-1:0] i_fwdWaddr,
  input  logic [NUM_FWD-1:0]        i_fwdDataOk,
  input  logic [NUM_FWD*XLEN-1:0]   i_fwdData,
  input  logic                      i_retireValid,
  input  logic [REG_AW-1:0]         i_retireWaddr,
  input  logic [XLEN-1:0]           i_retireWdata,
  output logic [XLEN-1:0]           o_value,
  output logic                      o_stall
);

`ifdef SB_BYPASS_EN
  logic            w_hit;
  logic            w_hitOk;
  logic [XLEN-1:0] w_hitData;

  // Scan oldest to youngest so the lowest matching index overrides the rest.
  always_comb begin
    w_hit     = 1'b0;
    w_hitOk   = 1'b0;
    w_hitData = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwdValid[i] && i_fwdWe[i] && (i_fwdWaddr[i*REG_AW +: REG_AW] == i_addr)) begin
        w_hit     = 1'b1;
        w_hitOk   = i_fwdDataOk[i];
        w_hitData = i_fwdData[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_value = i_rfData;
    o_stall = 1'b0;
    if (i_addr == '0) begin
      o_value = '0;
    end else if (w_hit) begin
      if (w_hitOk) o_value = w_hitData;
      else         o_stall = i_need;
    end else if (i_retireValid && (i_retireWaddr == i_addr)) begin
      o_value = i_retireWdata;
    end else if (i_pending) begin
      o_stall = i_need;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_fwdValid, i_fwdWe, i_fwdWaddr, i_fwdDataOk, i_fwdData,
                      i_retireValid, i_retireWaddr, i_retireWdata};

  // Without bypass a pending write is only visible once it has reached the file.
  always_comb begin
    o_value = (i_addr == '0) ? '0 : i_rfData;
    o_stall = (i_addr != '0) && i_need && i_pending;
  end
`endif

endmodule

// File: rtl/id_operand_scoreboard.sv
// Decode-stage operand scoreboard: per-register pending counters plus one resolver per read port.
// Define SB_BYPASS_EN to enable forwarding/commit bypass; otherwise operands come from the file.
module id_operand_scoreboard
  import id_sb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 2
) (
  input logic              clk,
  input logic              reset,
  id_operand_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cntMax(CNT_W));

  logic [CNT_W-1:0]  r_cnt [NREG];
  logic              r_sbErr;
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic [NREG-1:0]   w_busy;
  logic              w_zeroRetire;
  logic              w_satStall;
  logic [NUM_RD-1:0] w_portStall;

  always_comb begin
    w_inc  = '0;
    w_dec  = '0;
    w_busy = '0;
    for (int r = 1; r < NREG; r++) begin
      w_inc[r] = sb.issue_valid && sb.issue_we && (sb.issue_waddr == REG_AW'(r));
      w_dec[r] = sb.retire_valid && (sb.retire_waddr == REG_AW'(r));
    end
    for (int r = 0; r < NREG; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  // A simultaneous issue to the same register cancels the retire, so it is not an error.
  assign w_zeroRetire = sb.retire_valid && (sb.retire_waddr != '0)
                      && !(sb.issue_valid && sb.issue_we && (sb.issue_waddr == sb.retire_waddr))
                      && (r_cnt[sb.retire_waddr] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_sbErr <= 1'b0;
    end else if (sb.flush_all) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r] && (r_cnt[r] != CNT_MAX)) r_cnt[r] <= r_cnt[r] + 1'b1;
        else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) r_cnt[r] <= r_cnt[r] - 1'b1;
      end
      if (w_zeroRetire) r_sbErr <= 1'b1;
    end
  end

  // Holding decode while the destination counter is full keeps it from wrapping.
  assign w_satStall = sb.dst_we && (sb.dst_addr != '0) && (r_cnt[sb.dst_addr] == CNT_MAX);

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    id_fwd_mux #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD)
    ) u_fwdMux (
      .i_addr        (sb.rd_addr[p*REG_AW +: REG_AW]),
      .i_need        (sb.rd_need[p]),
      .i_rfData      (sb.rf_rdata[p*XLEN +: XLEN]),
      .i_pending     (w_busy[sb.rd_addr[p*REG_AW +: REG_AW]]),
      .i_fwdValid    (sb.fwd_valid),
      .i_fwdWe       (sb.fwd_we),
      .i_fwdWaddr    (sb.fwd_waddr),
      .i_fwdDataOk   (sb.fwd_data_ok),
      .i_fwdData     (sb.fwd_data),
      .i_retireValid (sb.retire_valid),
      .i_retireWaddr (sb.retire_waddr),
      .i_retireWdata (sb.retire_wdata),
      .o_value       (sb.src_value[p*XLEN +: XLEN]),
      .o_stall       (w_portStall[p])
    );
  end

  assign sb.stall     = (|w_portStall) || w_satStall;
  assign sb.busy_mask = w_busy;
  assign sb.sb_err    = r_sbErr;

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Directed plus randomized bench for id_operand_scoreboard against a behavioural model.
// Honours SB_BYPASS_EN the same way as the design build.
module tb_id_operand_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_operand_scoreboard_if #(.XLEN(32), .NREG(32), .NUM_RD(2), .NUM_FWD(3)) sbIf ();

  id_operand_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbIf)
  );

  int total = 0;
  int bad = 0;
  int mCnt [32];
  bit mErr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    sbIf.rd_addr = '0;      sbIf.rd_need = '0;     sbIf.rf_rdata = '0;
    sbIf.issue_valid = 0;   sbIf.issue_we = 0;     sbIf.issue_waddr = '0;
    sbIf.dst_addr = '0;     sbIf.dst_we = 0;
    sbIf.fwd_valid = '0;    sbIf.fwd_we = '0;      sbIf.fwd_waddr = '0;
    sbIf.fwd_data_ok = '0;  sbIf.fwd_data = '0;
    sbIf.retire_valid = 0;  sbIf.retire_waddr = '0; sbIf.retire_wdata = '0;
    sbIf.flush_all = 0;
  endtask

  task automatic setFwd(input int i, input bit v, input int a, input bit ok, input logic [31:0] d);
    sbIf.fwd_valid[i] = v;
    sbIf.fwd_we[i] = v;
    sbIf.fwd_waddr[i*5 +: 5] = 5'(a);
    sbIf.fwd_data_ok[i] = ok;
    sbIf.fwd_data[i*32 +: 32] = d;
  endtask

  // Resolution rules for one read port, from the current model counters.
  function automatic void modelPort(input int p, output logic [31:0] val, output bit st, output bit known);
    int a;
    a = int'(sbIf.rd_addr[p*5 +: 5]);
    val = sbIf.rf_rdata[p*32 +: 32];
    st = 0;
    known = 1;
    if (a == 0) begin
      val = '0;
      return;
    end
`ifdef SB_BYPASS_EN
    for (int i = 0; i < 3; i++) begin
      if (sbIf.fwd_valid[i] && sbIf.fwd_we[i] && int'(sbIf.fwd_waddr[i*5 +: 5]) == a) begin
        if (sbIf.fwd_data_ok[i]) val = sbIf.fwd_data[i*32 +: 32];
        else begin st = sbIf.rd_need[p]; known = 0; end
        return;
      end
    end
    if (sbIf.retire_valid && int'(sbIf.retire_waddr) == a) begin
      val = sbIf.retire_wdata;
      return;
    end
    if (mCnt[a] != 0) begin st = sbIf.rd_need[p]; known = 0; end
`else
    if (mCnt[a] != 0) st = sbIf.rd_need[p];
`endif
  endfunction

  task automatic checkComb(input string tag);
    logic [31:0] val;
    bit st, known, expStall;
    expStall = sbIf.dst_we && sbIf.dst_addr != 0 && mCnt[sbIf.dst_addr] == 3;
    for (int p = 0; p < 2; p++) begin
      modelPort(p, val, st, known);
      expStall |= st;
      if (known) checkOutput($sformatf("%s src%0d", tag, p), 64'(sbIf.src_value[p*32 +: 32]), 64'(val));
    end
    checkOutput({tag, " stall"}, 64'(sbIf.stall), 64'(expStall));
  endtask

  task automatic modelUpdate();
    int inc, dec;
    if (reset) begin
      foreach (mCnt[r]) mCnt[r] = 0;
      mErr = 0;
    end else if (sbIf.flush_all) begin
      foreach (mCnt[r]) mCnt[r] = 0;
    end else begin
      inc = (sbIf.issue_valid && sbIf.issue_we && sbIf.issue_waddr != 0) ? int'(sbIf.issue_waddr) : -1;
      dec = (sbIf.retire_valid && sbIf.retire_waddr != 0) ? int'(sbIf.retire_waddr) : -1;
      if (!(inc >= 0 && inc == dec)) begin
        if (inc >= 0 && mCnt[inc] < 3) mCnt[inc]++;
        if (dec >= 0) begin
          if (mCnt[dec] == 0) mErr = 1;
          else mCnt[dec]--;
        end
      end
    end
  endtask

  task automatic stepClock(input string tag);
    logic [31:0] expMask;
    @(posedge clk);
    modelUpdate();
    #1;
    for (int r = 0; r < 32; r++) expMask[r] = (mCnt[r] != 0);
    checkOutput({tag, " busy"}, 64'(sbIf.busy_mask), 64'(expMask));
    checkOutput({tag, " err"}, 64'(sbIf.sb_err), 64'(mErr));
  endtask

  task automatic runCycle(input string tag);
    #1;
    checkComb(tag);
    stepClock(tag);
  endtask

  task automatic applyStimulus();
    int r;
    clearInputs();
    sbIf.rd_addr = 10'({$urandom_range(7), $urandom_range(7)} & 10'h3ff);
    sbIf.rd_addr[4:0] = 5'($urandom_range(7));
    sbIf.rd_addr[9:5] = 5'($urandom_range(7));
    sbIf.rd_need = 2'($urandom);
    sbIf.rf_rdata = {$urandom, $urandom};
    sbIf.dst_addr = 5'($urandom_range(7));
    sbIf.dst_we = 1'($urandom);
    for (int i = 0; i < 3; i++)
      setFwd(i, ($urandom_range(2) == 0), $urandom_range(7), 1'($urandom), $urandom);
    r = $urandom_range(7);
    if ($urandom_range(1) == 1 && mCnt[r] < 3) begin
      sbIf.issue_valid = 1; sbIf.issue_we = 1'($urandom_range(3) != 0); sbIf.issue_waddr = 5'(r);
    end
    r = $urandom_range(7);
    if ((mCnt[r] > 0 && $urandom_range(2) != 0) || $urandom_range(49) == 0) begin
      sbIf.retire_valid = 1; sbIf.retire_waddr = 5'(r); sbIf.retire_wdata = $urandom;
    end
    sbIf.flush_all = ($urandom_range(39) == 0);
    reset = ($urandom_range(99) == 0);
  endtask

  initial begin
    clearInputs();
    foreach (mCnt[i]) mCnt[i] = 0;
    mErr = 0;
    reset = 1;
    stepClock("reset0");
    stepClock("reset1");
    reset = 0;
    checkOutput("reset busy", 64'(sbIf.busy_mask), 64'd0);
    checkOutput("reset err", 64'(sbIf.sb_err), 64'd0);

    // Idle operands straight from the register file.
    sbIf.rd_addr = {5'd6, 5'd5}; sbIf.rd_need = 2'b11;
    sbIf.rf_rdata = {32'h6666_0006, 32'h5555_0005};
    #1;
    checkOutput("idle stall", 64'(sbIf.stall), 64'd0);
    checkOutput("idle src", 64'(sbIf.src_value), {32'h6666_0006, 32'h5555_0005});
    runCycle("idle");

    sbIf.issue_valid = 1; sbIf.issue_we = 1; sbIf.issue_waddr = 5'd5;
    runCycle("issue r5");
    sbIf.issue_valid = 0;
    checkOutput("busy r5", 64'(sbIf.busy_mask[5]), 64'd1);
    setFwd(0, 1, 5, 1, 32'h1234);
    runCycle("fwd ex r5");

    // Load in EX shadows an older MEM match.
    sbIf.issue_valid = 1; sbIf.issue_waddr = 5'd7;
    setFwd(0, 0, 0, 0, 0);
    runCycle("issue r7");
    sbIf.issue_valid = 0;
    sbIf.rd_addr = {5'd6, 5'd7};
    setFwd(0, 1, 7, 0, 32'h0);
    setFwd(1, 1, 7, 1, 32'hAAAA);
    runCycle("load r7");
    setFwd(0, 0, 0, 0, 0);
    setFwd(1, 1, 7, 1, 32'hBEEF);
    runCycle("mem r7");
    setFwd(1, 0, 0, 0, 0);

    // Three issues to r3 fill its counter.
    sbIf.rd_need = 2'b00;
    sbIf.issue_valid = 1; sbIf.issue_waddr = 5'd3;
    for (int k = 0; k < 3; k++) runCycle($sformatf("issue r3 #%0d", k));
    sbIf.issue_valid = 0;
    sbIf.dst_addr = 5'd3; sbIf.dst_we = 1;
    #1;
    checkOutput("sat stall", 64'(sbIf.stall), 64'd1);
    sbIf.issue_valid = 1; sbIf.retire_valid = 1; sbIf.retire_waddr = 5'd3;
    runCycle("issue+retire r3");
    clearInputs();
    checkOutput("r3 held busy", 64'(sbIf.busy_mask[3]), 64'd1);
    sbIf.dst_addr = 5'd3; sbIf.dst_we = 1;
    #1;
    checkOutput("sat stall held", 64'(sbIf.stall), 64'd1);
    sbIf.dst_we = 0;

    sbIf.retire_valid = 1; sbIf.retire_waddr = 5'd9;
    runCycle("retire zero r9");
    sbIf.retire_valid = 0;
    checkOutput("err set", 64'(sbIf.sb_err), 64'd1);
    sbIf.issue_valid = 1; sbIf.issue_we = 1; sbIf.issue_waddr = 5'd2;
    runCycle("issue r2");
    sbIf.issue_waddr = 5'd4;
    runCycle("issue r4");
    sbIf.issue_valid = 0; sbIf.flush_all = 1;
    runCycle("flush");
    sbIf.flush_all = 0;
    checkOutput("flush busy", 64'(sbIf.busy_mask), 64'd0);
    checkOutput("flush err", 64'(sbIf.sb_err), 64'd1);

    // r8 waits for its commit when bypass is absent.
    sbIf.issue_valid = 1; sbIf.issue_waddr = 5'd8;
    runCycle("issue r8");
    sbIf.issue_valid = 0;
    sbIf.rd_addr = {5'd0, 5'd8}; sbIf.rd_need = 2'b01; sbIf.rf_rdata = {32'h0, 32'h8888_0008};
    setFwd(0, 1, 8, 1, 32'h0808);
`ifndef SB_BYPASS_EN
    #1;
    checkOutput("r8 no-bypass stall", 64'(sbIf.stall), 64'd1);
`endif
    runCycle("fwd r8");
    setFwd(0, 0, 0, 0, 0);
    sbIf.retire_valid = 1; sbIf.retire_waddr = 5'd8; sbIf.retire_wdata = 32'h0808;
    runCycle("retire r8");
    sbIf.retire_valid = 0;
    #1;
    checkOutput("r8 after stall", 64'(sbIf.stall), 64'd0);
    checkOutput("r8 after src", 64'(sbIf.src_value[31:0]), 64'h8888_0008);
    runCycle("after r8");

    sbIf.issue_valid = 1; sbIf.issue_waddr = 5'd12;
    runCycle("issue r12");
    clearInputs();
    reset = 1;
    runCycle("mid reset");
    reset = 0;
    checkOutput("mid reset busy", 64'(sbIf.busy_mask), 64'd0);
    checkOutput("mid reset err", 64'(sbIf.sb_err), 64'd0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus();
      runCycle($sformatf("rand%0d", n));
    end
    reset = 0;
    clearInputs();
    stepClock("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_operand_scoreboard.md
Name: id_operand_scoreboard

Overview:
- Parametrised decode-stage operand resolver. Successor to the fixed three-source compare-and-forward logic in the ID stage.
- Tracks in-flight register writes with per-register pending counters.
- Selects each source operand from N prioritised forwarding sources, the WB commit, or the register file.
- Raises a single stall when any needed operand is not yet producible, e.g. a load or a multicycle mul/div result.

Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers (r0 hardwired zero)
- NUM_RD, 2, operand read ports
- NUM_FWD, 3, forwarding sources; index 0 is youngest (EX), then MEM, then WB
- CNT_W, 2, pending-counter width; max in-flight writes per register is 2^CNT_W-1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rd_addr  in  NUM_RD*5  source register numbers
- rd_need  in  NUM_RD  port actually used by the decoded instruction
- rf_rdata  in  NUM_RD*XLEN  raw register file read data
- src_value  out  NUM_RD*XLEN  resolved operands
- stall  out  1  decode must hold
- issue_valid  in  1  ID→EX handshake fired this cycle
- issue_we  in  1  issued instruction writes a register
- issue_waddr  in  5  its destination
- dst_addr  in  5  destination of the instruction currently in ID (for the saturation check)
- dst_we  in  1  that instruction writes a register
- fwd_valid / fwd_we  in  NUM_FWD each  stage valid, stage writes a register
- fwd_waddr  in  NUM_FWD*5  stage destinations
- fwd_data_ok  in  NUM_FWD  stage result is available this cycle (0 for a load in EX or a busy divider)
- fwd_data  in  NUM_FWD*XLEN  stage results
- retire_valid  in  1  WB commit to the register file this cycle
- retire_waddr  in  5  commit destination
- retire_wdata  in  XLEN  commit data
- flush_all  in  1  exception/ertn flush; all in-flight work killed
- busy_mask  out  NREG  registered; bit i = counter[i]≠0
- sb_err  out  1  sticky; retire seen on a zero counter

Behaviour:
- Reset (synchronous, active-high): all counters 0, busy_mask 0, sb_err 0. src_value and stall are combinational; with rd_need=0 they give stall=0.
- Counter update, per register r≠0, at the clock edge:
  - +1 on issue_valid&issue_we&issue_waddr==r.
  - −1 on retire_valid&retire_waddr==r.
  - Both in the same cycle: no change.
  - Writes to r0 never counted.
- flush_all has priority over issue/retire: all counters cleared and busy_mask cleared next cycle. sb_err is held.
- Retire on a zero counter: counter stays 0, sb_err set.
- Saturation: if dst_we and counter[dst_addr]==2^CNT_W-1, stall asserts so the counter never wraps.
- Operand resolution per port p, combinational, same-cycle (0 latency):
  1. addr==0 → value 0, no stall contribution.
  2. Else scan fwd index 0..NUM_FWD-1. The first match is the lowest index with fwd_valid&fwd_we&fwd_waddr==addr.
     - If that match has data_ok → value fwd_data.
     - Else stall if rd_need[p]. Older matches are ignored.
  3. No fwd match, retire_valid&retire_waddr==addr → retire_wdata.
  4. No match, counter[addr]≠0 → stall if rd_need[p] (pending write not visible to any source).
  5. Otherwise → rf_rdata.
- stall = OR of per-port stalls and the saturation stall.
- Stall must not depend on issue_valid, which prevents a combinational loop.
- Reset mid-operation: in-flight state is discarded and counters restart from 0.

Optional Feature:
- Macro: SB_BYPASS_EN.
- Defined: full forwarding as above.
- Undefined: fwd_* and retire_wdata are ignored; src_value = rf_rdata (0 for r0). stall if rd_need[p] and counter[rd_addr[p]]≠0, plus the saturation stall. The consumer waits until the cycle after retire. Counters and sb_err behave identically.

Decomposition:
- Package id_sb_pkg: REG_AW=5, default XLEN/NREG, counter-max function, fwd source index constants (FWD_EX=0, FWD_MEM=1, FWD_WB=2).
- Sub-module id_fwd_mux: one read port's priority scan, rules 1–5. Instantiated NUM_RD times by generate.
- Counters live in the top module.

Test Plan:
- Reset then rd_addr={r5,r6}, need=11, counters 0, no fwd → stall=0, src_value=rf_rdata; busy_mask=0.
- Issue add r5 (issue_valid, waddr=5), next cycle EX fwd waddr=5 data_ok=1 data=0x1234 → src_value[0]=0x1234, stall=0; busy_mask[5]=1.
- Load r7 in EX (data_ok=0) and r7 also in MEM with 0xAAAA → stall=1 (youngest wins). Next cycle MEM data_ok=1 data=0xBEEF → src=0xBEEF, stall=0.
- Issue r3 three times without retire (CNT_W=2), dst_addr=3 dst_we=1 → stall=1. Issue and retire r3 together → counter stays 3.
- Retire r9 with counter 0 → sb_err=1 and sticky. flush_all with busy r2,r4 → busy_mask=0 next cycle, sb_err still 1.
- SB_BYPASS_EN undefined: issue r8, fwd EX r8 data_ok=1 → stall=1 until the cycle after retire r8, then src=rf_rdata.
